parity_stream_xor: RTL
======================

Name: parity_stream_xor

Overview:
Parametrised, registered successor to the lab's two-input XOR. It accepts a stream of WIDTH-bit words framed by a last flag and accumulates a bitwise XOR checksum and a parity bit across each frame. It presents one frame result per frame on a valid/ready output port. It sits between a switch/UART-style word source and a display or checker stage in the lab top level.

Parameters:
WIDTH, 8, data word width in bits (must be 1 or more)
MAX_WORDS, 255, frame length at which the word counter saturates and the overflow flag is set
CNT_W, $clog2(MAX_WORDS+1), counter width (derived; not overridden by users)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data / in_last are valid
in_ready  output  1  block accepts a word this cycle
in_data  input  WIDTH  input word
in_last  input  1  word is the final word of its frame
odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on the first word of each frame
res_valid  output  1  frame result valid
res_ready  input  1  downstream accepts the result
res_xor  output  WIDTH  bitwise XOR of all words in the frame
res_parity  output  1  (^res_xor) XOR the latched odd_mode
res_count  output  CNT_W  number of words in the frame, saturating at MAX_WORDS
res_ovf  output  1  frame had more than MAX_WORDS words

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. While reset is asserted, all state clears:
  - state = S_IDLE; accumulator, count, ovf and latched mode = 0.
  - res_valid = 0, res_xor = 0, res_parity = 0, res_count = 0, res_ovf = 0.
  - in_ready = 1 one cycle after reset is released.
- Accept rule: a word is accepted when in_valid & in_ready on a rising clk edge.
- Ready rule: in_ready = !res_valid | res_ready. This is combinational from res_ready; there is no skid buffer.
- Result handshake: a result is consumed on res_valid & res_ready.
- FSM states:
  - S_IDLE: no frame in progress.
  - S_ACCUM: at least one non-last word accepted.
- S_IDLE, accepted word:
  - acc <= in_data; cnt <= 1; mode <= odd_mode.
  - If in_last, publish directly from these values and stay in S_IDLE.
  - Otherwise go to S_ACCUM.
- S_ACCUM, accepted word:
  - acc <= acc ^ in_data.
  - cnt <= cnt + 1, saturating at MAX_WORDS.
  - ovf <= 1 if cnt == MAX_WORDS at the time of the accept.
  - If in_last: publish and return to S_IDLE.
- odd_mode changes during S_ACCUM are ignored for the current frame.
- Publish:
  - On the edge the last word is accepted: res_xor <= final acc; res_count <= final cnt; res_ovf <= final ovf; res_parity <= ^final_acc ^ mode; res_valid <= 1.
  - Latency: result is visible the cycle after in_last is accepted.
  - Internal accumulators clear on the same edge.
- res_valid is held until consumed. Result outputs must remain stable while res_valid & !res_ready.
- Simultaneous consume and publish in one cycle: the new result overwrites and res_valid stays 1. No bubble is allowed.
- While res_valid & !res_ready: in_ready = 0, so no words are accepted, including non-last words.
- in_valid with in_ready = 0: no state change.
- Reset mid-frame or with a result pending: the partial frame and pending result are discarded. The first word after reset starts a new frame.
- WIDTH = 1: degenerates to a serial parity accumulator. It must still synthesise and pass the bench.

Decomposition:
- Package parity_pkg holds:
  - the state enum {S_IDLE, S_ACCUM};
  - localparams for default WIDTH and MAX_WORDS;
  - the parity mode constants EVEN = 0, ODD = 1.
- Sub-module xor_reduce #(WIDTH): combinational N-input XOR reduction. It is the generalised form of the two-input XOR and is instantiated once for res_parity.
- All other logic lives in parity_stream_xor.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with in_valid = 0 -> res_valid = 0 and all res_* = 0; in_ready = 1 after release.
- Basic frame, WIDTH = 8, even mode, res_ready = 1: words 0x01, 0x02, 0x04 (last on 0x04) -> one cycle later res_xor = 0x07, res_parity = 1, res_count = 3, res_ovf = 0, res_valid for 1 cycle.
- Odd mode and single-word frame: odd_mode = 1, word 0xFF with last -> res_xor = 0xFF, res_parity = 1, res_count = 1. Also toggle odd_mode mid-frame on 0x0F, 0xF0 (last) with odd_mode = 0 at start -> res_parity = 0.
- Backpressure: res_ready = 0 after the first frame (0xAA, last) -> in_ready = 0, outputs stable for 5 cycles. Present the second frame 0x55 (last) throughout. Raise res_ready -> first result consumed, 0x55 accepted the same cycle, next cycle res_xor = 0x55, res_valid stays 1.
- Saturation, MAX_WORDS = 4: frame of 6 words of 0x01 -> res_count = 4, res_ovf = 1, res_xor = 0x00, res_parity = 0.
- Reset mid-frame: 0x3C accepted, rst_n pulsed asynchronously between edges, then 0x01 (last) -> res_xor = 0x01, res_count = 1.

Source files
------------

// File: rtl/parity_stream_xor_pkg.sv
// Shared types and constants for the parity/XOR frame accumulator.
package parity_pkg;

    // Frame tracking: idle between frames, accumulating once a non-last word is in.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_MAX_WORDS = 255;

    // Parity mode encoding as seen on odd_mode.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/parity_stream_xor_if.sv
// Word-stream input and frame-result output bundle for parity_stream_xor.
interface parity_stream_xor_if
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) ();

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    // Word stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;

    // Frame result
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_xor;
    logic             res_parity;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    // Source of words / sink of results (testbench or lab top level).
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        output odd_mode,
        input  res_valid,
        output res_ready,
        input  res_xor,
        input  res_parity,
        input  res_count,
        input  res_ovf
    );

    // The accumulator itself.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        input  odd_mode,
        output res_valid,
        input  res_ready,
        output res_xor,
        output res_parity,
        output res_count,
        output res_ovf
    );

endinterface

// File: rtl/parity_stream_xor_xor_reduce.sv
// N-input XOR reduction; the generalised form of the lab's two-input XOR.
module xor_reduce #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             red
);

    // Fold every bit into a single parity bit.
    always_comb begin
        red = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            red = red ^ data[i];
        end
    end

endmodule

// File: rtl/parity_stream_xor.sv
// Frame-level XOR checksum and parity accumulator with a registered
// valid/ready result port. One result is published per in_last word.
module parity_stream_xor
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input logic                clk,
    input logic                rst_n,
    parity_stream_xor_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Frame-in-progress state
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;

    // Result register
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_xor_q, res_xor_d;
    logic             res_parity_q, res_parity_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;

    // Frame totals including the word being accepted this cycle
    logic [WIDTH-1:0] fin_acc;
    logic [CNT_W-1:0] fin_cnt;
    logic             fin_ovf;
    logic             fin_mode;
    logic             fin_red;

    logic in_ready;
    logic accept;
    logic consume;

    // No skid buffer: a pending result blocks input unless it leaves this cycle.
    assign in_ready = !res_valid_q || bus.res_ready;
    assign accept   = bus.in_valid && in_ready;
    assign consume  = res_valid_q && bus.res_ready;

    // Fold the incoming word into the running frame; a first word restarts it.
    always_comb begin
        fin_acc  = bus.in_data;
        fin_cnt  = CNT_ONE;
        fin_ovf  = 1'b0;
        fin_mode = bus.odd_mode;
        if (state_q == S_ACCUM) begin
            fin_acc  = acc_q ^ bus.in_data;
            fin_cnt  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            fin_ovf  = ovf_q || (cnt_q == CNT_MAX);
            fin_mode = mode_q;
        end
    end

    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_xor_reduce (
        .data (fin_acc),
        .red  (fin_red)
    );

    // Next-state: accumulate non-last words, publish and clear on the last one.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        mode_d       = mode_q;
        res_valid_d  = res_valid_q;
        res_xor_d    = res_xor_q;
        res_parity_d = res_parity_q;
        res_count_d  = res_count_q;
        res_ovf_d    = res_ovf_q;

        if (consume) begin
            res_valid_d = 1'b0;
        end

        if (accept) begin
            if (bus.in_last) begin
                // A publish in the same cycle as a consume overwrites without a bubble.
                res_valid_d  = 1'b1;
                res_xor_d    = fin_acc;
                res_parity_d = fin_red ^ (fin_mode == ODD);
                res_count_d  = fin_cnt;
                res_ovf_d    = fin_ovf;
                state_d      = S_IDLE;
                acc_d        = '0;
                cnt_d        = '0;
                ovf_d        = 1'b0;
                mode_d       = EVEN;
            end else begin
                state_d = S_ACCUM;
                acc_d   = fin_acc;
                cnt_d   = fin_cnt;
                ovf_d   = fin_ovf;
                mode_d  = fin_mode;
            end
        end
    end

    // State and result registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            mode_q       <= EVEN;
            res_valid_q  <= 1'b0;
            res_xor_q    <= '0;
            res_parity_q <= 1'b0;
            res_count_q  <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            mode_q       <= mode_d;
            res_valid_q  <= res_valid_d;
            res_xor_q    <= res_xor_d;
            res_parity_q <= res_parity_d;
            res_count_q  <= res_count_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_xor    = res_xor_q;
    assign bus.res_parity = res_parity_q;
    assign bus.res_count  = res_count_q;
    assign bus.res_ovf    = res_ovf_q;

endmodule
